fifo_flags_n: RTL and testbench

Parametrised synchronous FIFO and next generation of fifo_diag.
- Generalises data width and depth; depth need not be a power of two.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a first-word-fall-through (FWFT) read mode.
- Keeps the diag_state/diag_waddr/diag_raddr observability ports.
- Sits between byte/word producers and consumers in the lab FPGA designs.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_wrap_ptr.sv | 34 +++
 rtl/fifo_flags_n.sv | 135 +++++++++++++
 tb/tb_fifo_flags_n.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the fifo_flags_n FIFO family.
package fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_t;

    // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 values.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer; wraps by explicit compare so any depth works.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flags_n.sv
// Parametrised synchronous FIFO with occupancy, threshold flags, sticky
// error flags, optional first-word-fall-through and pointer diagnostics.
module fifo_flags_n
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0,
    localparam int CW = count_width(DEPTH),
    localparam int AW = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             read,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err,
    output logic [1:0]       diag_state,
    output logic [AW-1:0]    diag_waddr,
    output logic [AW-1:0]    diag_raddr
);

    if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
        $fatal(1, "fifo_flags_n: DEPTH must be in 2..1024");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $fatal(1, "fifo_flags_n: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "fifo_flags_n: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic             wr_ok;
    logic             rd_ok;
    logic [CW-1:0]    count_q,  count_d;
    logic             empty_q,  empty_d;
    logic             full_q,   full_d;
    logic             aempty_q, aempty_d;
    logic             afull_q,  afull_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic [WIDTH-1:0] rdata_q,  rdata_d;
    fifo_state_t      state_q,  state_d;

    // Flags are derived from the next count so they move together with count.
    always_comb begin
        wr_ok   = write & ~full_q;
        rd_ok   = read & ~empty_q;
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
        empty_d  = (count_d == '0);
        full_d   = (count_d == CW'(DEPTH));
        aempty_d = (count_d <= CW'(AEMPTY_THRESH));
        afull_d  = (count_d >= CW'(AFULL_THRESH));
        state_d  = empty_d ? FIFO_EMPTY : (full_d ? FIFO_FULL : FIFO_PARTIAL);
        ovf_d    = (write & full_q) | (ovf_q & ~clr_err);
        unf_d    = (read & empty_q) | (unf_q & ~clr_err);
        rdata_d  = rd_ok ? mem_q[raddr] : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= '0;
            state_q  <= FIFO_EMPTY;
        end else begin
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_ok),
        .ptr (waddr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_ok),
        .ptr (raddr)
    );

    // In FWFT mode the head word is exposed directly, gated to zero when empty.
    assign rdata        = (FWFT != 0) ? (empty_q ? '0 : mem_q[raddr]) : rdata_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign diag_state   = state_q;
    assign diag_waddr   = waddr;
    assign diag_raddr   = raddr;

endmodule

// File: tb/tb_fifo_flags_n.sv
// Directed, scoreboard-checked bench for fifo_flags_n in three configurations.
module tb_fifo_flags_n;

    logic       clk;
    logic       rst;
    logic       write;
    logic [7:0] wdata;
    logic       read;
    logic       clr_err;

    // Instance A: DEPTH=5, registered read, default thresholds (AF=4, AE=1)
    logic [7:0] rdata_a;
    logic       empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
    logic [2:0] count_a;
    logic [1:0] state_a;
    logic [2:0] waddr_a, raddr_a;

    // Instance B: DEPTH=8, AF=6, AE=2
    logic [7:0] rdata_b;
    logic       empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
    logic [3:0] count_b;
    logic [1:0] state_b;
    logic [2:0] waddr_b, raddr_b;

    // Instance C: DEPTH=5, first-word-fall-through
    logic [7:0] rdata_c;
    logic       empty_c, full_c, ae_c, af_c, ovf_c, unf_c;
    logic [2:0] count_c;
    logic [1:0] state_c;
    logic [2:0] waddr_c, raddr_c;

    int tests = 0;
    int fails = 0;

    // Reference model of instance A
    logic [7:0] m_q  [$];
    logic [7:0] sb_q [$];
    int         m_waddr;
    int         m_raddr;
    logic       m_ovf;
    logic       m_unf;

    fifo_flags_n #(.WIDTH(8), .DEPTH(5), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .write(write), .wdata(wdata), .read(read),
        .rdata(rdata_a), .empty(empty_a), .full(full_a), .almost_empty(ae_a),
        .almost_full(af_a), .count(count_a), .overflow(ovf_a), .underflow(unf_a),
        .clr_err(clr_err), .diag_state(state_a), .diag_waddr(waddr_a), .diag_raddr(raddr_a)
    );

    fifo_flags_n #(.WIDTH(8), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)) dut_b (
        .clk(clk), .rst(rst), .write(write), .wdata(wdata), .read(read),
        .rdata(rdata_b), .empty(empty_b), .full(full_b), .almost_empty(ae_b),
        .almost_full(af_b), .count(count_b), .overflow(ovf_b), .underflow(unf_b),
        .clr_err(clr_err), .diag_state(state_b), .diag_waddr(waddr_b), .diag_raddr(raddr_b)
    );

    fifo_flags_n #(.WIDTH(8), .DEPTH(5), .FWFT(1)) dut_c (
        .clk(clk), .rst(rst), .write(write), .wdata(wdata), .read(read),
        .rdata(rdata_c), .empty(empty_c), .full(full_c), .almost_empty(ae_c),
        .almost_full(af_c), .count(count_c), .overflow(ovf_c), .underflow(unf_c),
        .clr_err(clr_err), .diag_state(state_c), .diag_waddr(waddr_c), .diag_raddr(raddr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        m_q.delete();
        sb_q.delete();
        m_waddr = 0;
        m_raddr = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Drives one cycle; expected read data is queued at drive time and
    // compared once instance A has registered it.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic m_full, m_empty, wr_ok, rd_ok;
        write   = w;
        wdata   = d;
        read    = r;
        clr_err = c;
        m_full  = (m_q.size() == 5);
        m_empty = (m_q.size() == 0);
        wr_ok   = w && !m_full;
        rd_ok   = r && !m_empty;
        if (rd_ok) begin
            sb_q.push_back(m_q.pop_front());
            m_raddr = (m_raddr + 1) % 5;
        end
        if (wr_ok) begin
            m_q.push_back(d);
            m_waddr = (m_waddr + 1) % 5;
        end
        if (w && m_full) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (r && m_empty) m_unf = 1'b1;
        else if (c) m_unf = 1'b0;
        @(posedge clk);
        #1;
        if (rd_ok) checkOutput("a/rdata_sb", 32'(rdata_a), 32'(sb_q.pop_front()));
        write   = 1'b0;
        read    = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic modelCheck(input string tag);
        int n;
        n = m_q.size();
        checkOutput({tag, "/count"}, 32'(count_a), n);
        checkOutput({tag, "/empty"}, 32'(empty_a), 32'(n == 0));
        checkOutput({tag, "/full"}, 32'(full_a), 32'(n == 5));
        checkOutput({tag, "/aempty"}, 32'(ae_a), 32'(n <= 1));
        checkOutput({tag, "/afull"}, 32'(af_a), 32'(n >= 4));
        checkOutput({tag, "/overflow"}, 32'(ovf_a), 32'(m_ovf));
        checkOutput({tag, "/underflow"}, 32'(unf_a), 32'(m_unf));
        checkOutput({tag, "/state"}, 32'(state_a), (n == 0) ? 0 : ((n == 5) ? 2 : 1));
        checkOutput({tag, "/waddr"}, 32'(waddr_a), m_waddr);
        checkOutput({tag, "/raddr"}, 32'(raddr_a), m_raddr);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        resetModel();
    endtask

    initial begin
        rst     = 1'b1;
        write   = 1'b0;
        wdata   = '0;
        read    = 1'b0;
        clr_err = 1'b0;
        resetModel();
        #12;
        rst = 1'b0;

        // Reset state
        modelCheck("reset");
        checkOutput("reset/rdata", 32'(rdata_a), 0);
        checkOutput("reset/b_count", 32'(count_b), 0);
        checkOutput("reset/c_rdata", 32'(rdata_c), 0);

        // Fill DEPTH=5, overflow on sixth write, drain in order
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            modelCheck("fill");
        end
        checkOutput("fill/full", 32'(full_a), 1);
        checkOutput("fill/count5", 32'(count_a), 5);
        checkOutput("fill/waddr_wrap", 32'(waddr_a), 0);
        applyStimulus(1'b1, 8'h06, 1'b0, 1'b0);
        checkOutput("ovf/overflow", 32'(ovf_a), 1);
        checkOutput("ovf/count", 32'(count_a), 5);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain/rdata", 32'(rdata_a), i);
            modelCheck("drain");
        end

        // Underflow on empty read, then clear
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("unf/underflow", 32'(unf_a), 1);
        checkOutput("unf/count", 32'(count_a), 0);
        checkOutput("unf/raddr", 32'(raddr_a), 0);
        checkOutput("unf/waddr", 32'(waddr_a), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr/underflow", 32'(unf_a), 0);
        checkOutput("clr/overflow", 32'(ovf_a), 0);

        // Simultaneous read/write: partial, full, empty
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
        checkOutput("rw_part/count", 32'(count_a), 2);
        checkOutput("rw_part/waddr", 32'(waddr_a), 3);
        checkOutput("rw_part/raddr", 32'(raddr_a), 1);
        modelCheck("rw_part");
        applyStimulus(1'b1, 8'h13, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h14, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h15, 1'b0, 1'b0);
        modelCheck("refill");
        applyStimulus(1'b1, 8'h16, 1'b1, 1'b0);
        checkOutput("rw_full/count", 32'(count_a), 4);
        checkOutput("rw_full/overflow", 32'(ovf_a), 1);
        checkOutput("rw_full/rdata", 32'(rdata_a), 32'h11);
        modelCheck("rw_full");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        modelCheck("drain2");
        applyStimulus(1'b1, 8'h17, 1'b1, 1'b0);
        checkOutput("rw_empty/count", 32'(count_a), 1);
        checkOutput("rw_empty/underflow", 32'(unf_a), 1);
        modelCheck("rw_empty");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("rw_empty/rdata", 32'(rdata_a), 32'h17);
        modelCheck("rw_empty_drain");

        // Thresholds on DEPTH=8, AF=6, AE=2
        doReset();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
            checkOutput($sformatf("thr_up%0d/count", k), 32'(count_b), k);
            checkOutput($sformatf("thr_up%0d/aempty", k), 32'(ae_b), 32'(k <= 2));
            checkOutput($sformatf("thr_up%0d/afull", k), 32'(af_b), 32'(k >= 6));
        end
        checkOutput("thr/full", 32'(full_b), 1);
        for (int k = 7; k >= 0; k--) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput($sformatf("thr_dn%0d/count", k), 32'(count_b), k);
            checkOutput($sformatf("thr_dn%0d/aempty", k), 32'(ae_b), 32'(k <= 2));
            checkOutput($sformatf("thr_dn%0d/afull", k), 32'(af_b), 32'(k >= 6));
        end
        checkOutput("thr/rdata_last", 32'(rdata_b), 32'h28);
        modelCheck("thr_a");

        // FWFT behaviour and asynchronous reset
        doReset();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("fwft/first_word", 32'(rdata_c), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("fwft/hold", 32'(rdata_c), 32'hA5);
        applyStimulus(1'b1, 8'hB6, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC7, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("fwft/advance", 32'(rdata_c), 32'hB6);
        applyStimulus(1'b1, 8'hD8, 1'b0, 1'b0);
        checkOutput("fwft/count3", 32'(count_c), 3);
        rst = 1'b1;
        #1;
        checkOutput("arst/empty", 32'(empty_c), 1);
        checkOutput("arst/rdata", 32'(rdata_c), 0);
        checkOutput("arst/count", 32'(count_c), 0);
        #2;
        rst = 1'b0;
        resetModel();
        modelCheck("arst_a");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
